// File: rtl/axi4s_pattern_gen.sv
// AXI4-Stream burst pattern generator: emits a commanded number of beats (increment, LFSR,
// constant or rotate-left) under tvalid/tready flow control and pulses o_done at burst end.
module axi4s_pattern_gen #(
    parameter int unsigned AXI4SDATALEN = 32,
    parameter int unsigned CLEN = 16,
    parameter logic [AXI4SDATALEN-1:0] TAPS = 32'h8020_0003
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_start,
    input  logic [CLEN-1:0]         i_count,
    input  logic [AXI4SDATALEN-1:0] i_seed,
    input  logic [1:0]              i_mode,
    input  logic                    i_abort,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [CLEN-1:0]         o_beats,
    output logic                    tx_tvalid,
    output logic [AXI4SDATALEN-1:0] tx_tdata,
    input  logic                    tx_tready
);

    localparam int unsigned DLEN = AXI4SDATALEN;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [DLEN-1:0]   data_q, data_d;
    logic [CLEN-1:0]   count_q, count_d;
    logic [1:0]        mode_q, mode_d;
    logic [CLEN-1:0]   beats_q, beats_d;
    logic              tvalid_q, tvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              handshake;

    function automatic logic [DLEN-1:0] advance(input logic [DLEN-1:0] data,
                                                input logic [1:0] mode);
        logic [DLEN-1:0] nxt;
        nxt = data;
        case (mode)
            2'd0:    nxt = data + DLEN'(1);
            2'd1:    nxt = {data[DLEN-2:0], 1'b0} ^ (data[DLEN-1] ? TAPS : '0);
            2'd2:    nxt = data;
            default: nxt = {data[DLEN-2:0], data[DLEN-1]};
        endcase
        return nxt;
    endfunction

    assign handshake = tvalid_q & tx_tready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        mode_d   = mode_q;
        beats_d  = beats_q;
        tvalid_d = tvalid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    count_d = i_count;
                    mode_d  = i_mode;
                    beats_d = '0;
                    busy_d  = 1'b1;
                    // An all-zero LFSR state would lock up, so substitute 1.
                    data_d  = (i_mode == 2'd1 && i_seed == '0) ? DLEN'(1) : i_seed;
                    if (i_count != '0) begin
                        state_d  = StRun;
                        tvalid_d = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort only takes effect on a handshake so valid is never withdrawn.
                if (handshake) begin
                    beats_d = beats_q + CLEN'(1);
                    data_d  = advance(data_q, mode_q);
                    if (beats_d == count_q || i_abort) begin
                        state_d  = StDone;
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = StIdle;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            data_q   <= '0;
            count_q  <= '0;
            mode_q   <= '0;
            beats_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            beats_q  <= beats_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_beats   = beats_q;
    assign tx_tvalid = tvalid_q;
    assign tx_tdata  = data_q;

endmodule

// File: tb/tb_axi4s_pattern_gen.sv
// Scoreboard bench for axi4s_pattern_gen: expected beats are queued at each start and popped
// by a monitor on every handshake; burst timing and status are checked by the driver.
module tb_axi4s_pattern_gen;

    localparam int unsigned DLEN = 32;
    localparam int unsigned CLEN = 16;
    localparam logic [DLEN-1:0] TAPS = 32'h8020_0003;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            i_start = 1'b0;
    logic [CLEN-1:0] i_count = '0;
    logic [DLEN-1:0] i_seed = '0;
    logic [1:0]      i_mode = '0;
    logic            i_abort = 1'b0;
    logic            o_busy;
    logic            o_done;
    logic [CLEN-1:0] o_beats;
    logic            tx_tvalid;
    logic [DLEN-1:0] tx_tdata;
    logic            tx_tready;

    int              checks = 0;
    int              failures = 0;
    logic [DLEN-1:0] exp_q[$];
    int              tready_mode = 0;
    logic            tready_manual = 1'b0;
    int              phase = 0;

    logic [1:0]      r_mode;
    logic [DLEN-1:0] r_seed;
    int              r_count;

    axi4s_pattern_gen #(
        .AXI4SDATALEN(DLEN),
        .CLEN        (CLEN),
        .TAPS        (TAPS)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_start  (i_start),
        .i_count  (i_count),
        .i_seed   (i_seed),
        .i_mode   (i_mode),
        .i_abort  (i_abort),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_beats  (o_beats),
        .tx_tvalid(tx_tvalid),
        .tx_tdata (tx_tdata),
        .tx_tready(tx_tready)
    );

    always #5 aclk = ~aclk;

    // 0: always ready, 1: random, 2: 1-0-0 pattern, other: tready_manual
    always @(posedge aclk) begin
        #2;
        case (tready_mode)
            0: tx_tready = 1'b1;
            1: tx_tready = 1'($urandom_range(0, 1));
            2: begin
                tx_tready = (phase == 0);
                phase = (phase + 1) % 3;
            end
            default: tx_tready = tready_manual;
        endcase
        if (tready_mode != 2) phase = 0;
    end

    function automatic logic [DLEN-1:0] model_next(input logic [DLEN-1:0] d,
                                                   input logic [1:0] m);
        case (m)
            2'd0:    return d + 32'd1;
            2'd1:    return (d << 1) ^ (d[DLEN-1] ? TAPS : 32'd0);
            2'd2:    return d;
            default: return (d << 1) | (d >> (DLEN - 1));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic            hold;
        logic [DLEN-1:0] held;
        logic [DLEN-1:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (tx_tvalid !== 1'b1 || tx_tdata !== held) begin
                        failures++;
                        $display("FAIL hold_stable: got tvalid=%b tdata=%h, expected 1 %h",
                                 tx_tvalid, tx_tdata, held);
                    end
                end
                if (tx_tvalid && tx_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_beat: got tdata=%h, expected no beat", tx_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_tdata !== e) begin
                            failures++;
                            $display("FAIL beat_data: got %h, expected %h (t=%0t)",
                                     tx_tdata, e, $time);
                        end
                    end
                end
                hold = tx_tvalid && !tx_tready;
                held = tx_tdata;
            end
        end
    endtask

    // Queue n_model beats from the reference model, then issue the start command.
    task automatic start_burst(input logic [CLEN-1:0] c, input logic [DLEN-1:0] s,
                               input logic [1:0] m, input int n_model);
        logic [DLEN-1:0] d;
        d = (m == 2'd1 && s == 32'd0) ? 32'd1 : s;
        for (int i = 0; i < n_model; i++) begin
            exp_q.push_back(d);
            d = model_next(d, m);
        end
        @(posedge aclk); #1;
        i_start = 1'b1;
        i_count = c;
        i_seed  = s;
        i_mode  = m;
        @(posedge aclk); #1;
        i_start = 1'b0;
        i_count = 16'($urandom);
        i_seed  = $urandom;
        i_mode  = 2'($urandom);
        check("busy_after_start", 32'(o_busy), 32'd1);
        if (c != '0) begin
            check("tvalid_after_start", 32'(tx_tvalid), 32'd1);
            if (exp_q.size() != 0) check("first_tdata", tx_tdata, exp_q[0]);
        end else begin
            check("tvalid_count0", 32'(tx_tvalid), 32'd0);
        end
    endtask

    // exp_k: cycle after start in which o_done is required (0 = any); poke_k: start retry cycle.
    task automatic wait_done(input int exp_k, input int poke_k, input int exp_beats);
        int dk;
        dk = 0;
        for (int k = 1; k <= 3000; k++) begin
            if (o_done) begin
                dk = k;
                break;
            end
            if (k == poke_k) begin
                i_start = 1'b1;
                i_count = 16'd50;
                i_seed  = 32'h0000_1234;
                i_mode  = 2'd2;
            end else begin
                i_start = 1'b0;
            end
            @(posedge aclk); #1;
        end
        i_start = 1'b0;
        checks++;
        if (dk == 0) begin
            failures++;
            $display("FAIL done_timeout: got no o_done, expected o_done within 3000 cycles");
        end
        if (exp_k != 0) check("done_cycle", dk, exp_k);
        check("tvalid_in_done", 32'(tx_tvalid), 32'd0);
        check("busy_in_done", 32'(o_busy), 32'd1);
        @(posedge aclk); #1;
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("busy_idle", 32'(o_busy), 32'd0);
        check("beats_final", 32'(o_beats), exp_beats);
        check("beats_all_sent", exp_q.size(), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_tdata", tx_tdata, 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_beats", 32'(o_beats), 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Increment with wrap, tready tied high
        tready_mode = 0;
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        start_burst(16'd4, 32'hFFFF_FFFE, 2'd0, 0);
        wait_done(5, 0, 4);

        // Rotate-left under 1-0-0 backpressure
        tready_mode = 2;
        exp_q.push_back(32'h8000_0001);
        exp_q.push_back(32'h0000_0003);
        exp_q.push_back(32'h0000_0006);
        start_burst(16'd3, 32'h8000_0001, 2'd3, 0);
        wait_done(0, 0, 3);

        // LFSR: zero seed becomes 1, then MSB feedback
        tready_mode = 0;
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'h0000_0004);
        start_burst(16'd3, 32'h0000_0000, 2'd1, 0);
        wait_done(4, 0, 3);
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8020_0003);
        start_burst(16'd2, 32'h8000_0000, 2'd1, 0);
        wait_done(3, 0, 2);

        // Abort while stalled: held beat goes out on the handshake, then DONE
        tready_mode = 4;
        tready_manual = 1'b0;
        start_burst(16'd100, 32'hA5A5_0000, 2'd0, 1);
        i_abort = 1'b1;
        repeat (3) begin
            @(posedge aclk); #1;
        end
        check("abort_hold_valid", 32'(tx_tvalid), 32'd1);
        tready_manual = 1'b1;
        @(posedge aclk); #1;
        tready_manual = 1'b0;
        i_abort = 1'b0;
        wait_done(1, 0, 1);

        // Zero count and abort ignored while idle
        tready_mode = 0;
        i_abort = 1'b1;
        start_burst(16'd0, 32'h0000_0055, 2'd2, 0);
        i_abort = 1'b0;
        wait_done(1, 0, 0);

        // Start retried mid-burst is ignored
        start_burst(16'd5, 32'd100, 2'd0, 5);
        wait_done(6, 2, 5);

        // Asynchronous reset during beat 2 of 8
        start_burst(16'd8, 32'h0000_0010, 2'd0, 8);
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", 32'(tx_tvalid), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_beats", 32'(o_beats), 32'd0);
        check("midrst_tdata", tx_tdata, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        start_burst(16'd3, 32'h0000_0020, 2'd3, 3);
        check("beats_restart", 32'(o_beats), 32'd0);
        wait_done(4, 0, 3);

        // Random bursts under random backpressure
        tready_mode = 1;
        for (int n = 0; n < 8; n++) begin
            r_mode  = 2'($urandom_range(0, 3));
            r_seed  = $urandom;
            r_count = $urandom_range(1, 24);
            start_burst(16'(r_count), r_seed, r_mode, r_count);
            wait_done(0, 0, r_count);
        end
        tready_mode = 0;
        for (int n = 0; n < 3; n++) begin
            r_mode  = 2'($urandom_range(0, 3));
            r_seed  = $urandom;
            r_count = $urandom_range(1, 16);
            start_burst(16'(r_count), r_seed, r_mode, r_count);
            wait_done(r_count + 1, 0, r_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
